// File: rtl/ipif_pkg.sv
// Shared definitions for IPIF register-bus initiators.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package ipif_pkg;

    // Initiator FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } ipif_state_e;

    localparam int IPIF_MAX_DATA_W = 256;

    // Read data returned when the slave never acknowledges.
    localparam logic [IPIF_MAX_DATA_W-1:0] IPIF_TIMEOUT_PATTERN = '1;

    localparam int IPIF_DEFAULT_TIMEOUT = 16;

    // Counter width able to hold TIMEOUT_CYCLES-1 (at least one bit).
    function automatic int ipif_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int IPIF_DEFAULT_CNT_W = ipif_cnt_width(IPIF_DEFAULT_TIMEOUT);

endpackage

// File: rtl/ipif_timeout_cnt.sv
// Clear/enable up-counter with a terminal-count flag, used as a bus-access watchdog.
// Latency: tc_o is a decode of the registered count (valid the cycle the count reaches TERMINAL).
// Backpressure: none; clr_i has priority over en_i and the count saturates at all-ones.
//
// Ports: clk_i/rst_ni (sync active-low), clr_i, en_i, tc_o.
module ipif_timeout_cnt
    import ipif_pkg::*;
#(
    parameter int WIDTH    = IPIF_DEFAULT_CNT_W,
    parameter int TERMINAL = IPIF_DEFAULT_TIMEOUT - 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ipif_reg_master.sv
// IPIF initiator: runs one single-beat register read/write per command and returns one response.
// Latency: accept edge 0 -> CS high -> ack sampled at edge 2 -> rsp_valid (1-cycle-ack slave); 4 cycles/command.
// Backpressure: one command in flight; cmd_ready low from accept until the response handshake.
//
// Ports: Bus2IP_Clk/Bus2IP_Resetn (sync active-low); cmd_* request channel; rsp_* response
// channel; Bus2IP_* registered bus outputs to the slave; IP2Bus_* slave returns.
// Optional: define IPIF_REG_MASTER_STATS_EN to add saturating stat_txn_count,
// stat_err_count and stat_timeout_count outputs.
module ipif_reg_master
    import ipif_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = IPIF_DEFAULT_TIMEOUT
) (
    input  logic                            Bus2IP_Clk,
    input  logic                            Bus2IP_Resetn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] cmd_be,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic                            rsp_error,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
    output logic                            Bus2IP_CS,
    output logic                            Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
    input  logic                            IP2Bus_RdAck,
    input  logic                            IP2Bus_WrAck,
    input  logic                            IP2Bus_Error
`ifdef IPIF_REG_MASTER_STATS_EN
    ,
    output logic [31:0]                     stat_txn_count,
    output logic [15:0]                     stat_err_count,
    output logic [15:0]                     stat_timeout_count
`endif
);

    localparam int BE_W  = C_S_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = ipif_cnt_width(TIMEOUT_CYCLES);
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] TMO_DATA =
        IPIF_TIMEOUT_PATTERN[C_S_AXI_DATA_WIDTH-1:0];

    ipif_state_e                   state_q;
    logic                          cs_q;
    logic                          rnw_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] data_q;
    logic [BE_W-1:0]               be_q;
    logic                          cmd_ready_q;
    logic                          rsp_valid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rsp_data_q;
    logic                          rsp_error_q;

    logic accept;
    logic ack_qual;
    logic rsp_hs;
    logic tmo_tc;

    assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    // Only the ack matching the access direction counts; the other one is ignored.
    assign ack_qual = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;
    assign rsp_hs = rsp_valid_q && rsp_ready;

    ipif_timeout_cnt #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_tmo_cnt (
        .clk_i  (Bus2IP_Clk),
        .rst_ni (Bus2IP_Resetn),
        .clr_i  (accept),
        .en_i   (state_q == ST_ACCESS),
        .tc_o   (tmo_tc)
    );

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= ST_IDLE;
            cs_q        <= 1'b0;
            rnw_q       <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // cmd_ready rises one cycle after reset release.
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        addr_q      <= cmd_addr;
                        data_q      <= cmd_data;
                        be_q        <= cmd_be;
                        rnw_q       <= cmd_rnw;
                        cs_q        <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // An ack in the expiry cycle still wins over the timeout.
                    if (ack_qual) begin
                        cs_q        <= 1'b0;
                        rsp_data_q  <= rnw_q ? IP2Bus_Data : '0;
                        rsp_error_q <= IP2Bus_Error;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (tmo_tc) begin
                        cs_q        <= 1'b0;
                        rsp_data_q  <= TMO_DATA;
                        rsp_error_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Late slave acks arrive here and are dropped.
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign Bus2IP_CS   = cs_q;
    assign Bus2IP_RNW  = rnw_q;
    assign Bus2IP_Addr = addr_q;
    assign Bus2IP_Data = data_q;
    assign Bus2IP_BE   = be_q;

`ifdef IPIF_REG_MASTER_STATS_EN
    logic        rsp_tmo_q;
    logic [31:0] txn_cnt_q;
    logic [15:0] err_cnt_q;
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            rsp_tmo_q <= 1'b0;
            txn_cnt_q <= '0;
            err_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            // Remembers whether the pending response came from the watchdog
            // rather than the slave; the last ACCESS cycle decides.
            if (state_q == ST_ACCESS) begin
                rsp_tmo_q <= !ack_qual && tmo_tc;
            end
            if (rsp_hs) begin
                if (txn_cnt_q != '1) txn_cnt_q <= txn_cnt_q + 1'b1;
                if (rsp_error_q && !rsp_tmo_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
                if (rsp_tmo_q && (tmo_cnt_q != '1)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign stat_txn_count     = txn_cnt_q;
    assign stat_err_count     = err_cnt_q;
    assign stat_timeout_count = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_ipif_reg_master.sv
// Bench for ipif_reg_master: a registered 2WO/2RW/2RO slave, a transaction-level model and a
// per-cycle compare process, plus directed commands with literal expectations.
// Slave map (word index = addr[4:2]): 0,1 write-only; 2,3 read/write; 4,5 read-only.
module tb_ipif_reg_master;

    localparam int TMO = 16;
    localparam logic [31:0] RO0_VAL = 32'hCAFEF00D;
    localparam logic [31:0] RO1_VAL = 32'h5A5A0001;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b1;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic [31:0] Bus2IP_Addr;
    logic        Bus2IP_CS;
    logic        Bus2IP_RNW;
    logic [31:0] Bus2IP_Data;
    logic [3:0]  Bus2IP_BE;
    logic [31:0] IP2Bus_Data;
    logic        IP2Bus_RdAck;
    logic        IP2Bus_WrAck;
    logic        IP2Bus_Error;
`ifdef IPIF_REG_MASTER_STATS_EN
    logic [31:0] stat_txn_count;
    logic [15:0] stat_err_count;
    logic [15:0] stat_timeout_count;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ipif_reg_master #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Resetn (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rnw       (cmd_rnw),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_be        (cmd_be),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_error     (rsp_error),
        .Bus2IP_Addr   (Bus2IP_Addr),
        .Bus2IP_CS     (Bus2IP_CS),
        .Bus2IP_RNW    (Bus2IP_RNW),
        .Bus2IP_Data   (Bus2IP_Data),
        .Bus2IP_BE     (Bus2IP_BE),
        .IP2Bus_Data   (IP2Bus_Data),
        .IP2Bus_RdAck  (IP2Bus_RdAck),
        .IP2Bus_WrAck  (IP2Bus_WrAck),
        .IP2Bus_Error  (IP2Bus_Error)
`ifdef IPIF_REG_MASTER_STATS_EN
        ,
        .stat_txn_count     (stat_txn_count),
        .stat_err_count     (stat_err_count),
        .stat_timeout_count (stat_timeout_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic bit rd_map(input logic [31:0] a);
        return (a < 32'h18) && (a[4:2] >= 3'd2);
    endfunction

    function automatic bit wr_map(input logic [31:0] a);
        return (a < 32'h18) && (a[4:2] <= 3'd3);
    endfunction

    // ---------------- slave: acks one cycle after seeing CS, so it re-acks once after CS drops
    logic [31:0] slv_regs [0:3];
    logic        slv_rdack, slv_wrack;
    logic [31:0] slv_rdat;
    bit          slv_err = 0;
    bit          junk_wrack = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            slv_rdack <= 1'b0;
            slv_wrack <= 1'b0;
            slv_rdat  <= '0;
            for (int i = 0; i < 4; i++) slv_regs[i] <= '0;
        end else begin
            slv_rdack <= Bus2IP_CS && Bus2IP_RNW && rd_map(Bus2IP_Addr);
            slv_wrack <= (Bus2IP_CS && !Bus2IP_RNW && wr_map(Bus2IP_Addr)) || (junk_wrack && Bus2IP_CS);
            case (Bus2IP_Addr[4:2])
                3'd2:    slv_rdat <= slv_regs[2];
                3'd3:    slv_rdat <= slv_regs[3];
                3'd4:    slv_rdat <= RO0_VAL;
                3'd5:    slv_rdat <= RO1_VAL;
                default: slv_rdat <= '0;
            endcase
            if (Bus2IP_CS && !Bus2IP_RNW && wr_map(Bus2IP_Addr))
                slv_regs[Bus2IP_Addr[3:2]] <= be_merge(slv_regs[Bus2IP_Addr[3:2]], Bus2IP_Data, Bus2IP_BE);
        end
    end

    assign IP2Bus_Data  = slv_rdat;
    assign IP2Bus_RdAck = slv_rdack;
    assign IP2Bus_WrAck = slv_wrack;
    assign IP2Bus_Error = slv_err && (slv_rdack || slv_wrack);

    // ---------------- transaction model: each command's outcome is decided from the slave map
    // at accept time (mapped -> 2-cycle access, unmapped -> TMO-cycle access and error).
    bit          m_init = 0;
    bit          m_busy, m_rdy, m_cs, m_rv, m_rnw, m_err, m_to;
    int          m_age, m_lat;
    logic [31:0] m_addr, m_wdat, m_rdat;
    logic [3:0]  m_be;
    logic [31:0] m_shadow [0:3];
    int          m_txn, m_errs, m_tmos;

    always @(posedge clk) begin
        m_init = 1;
        if (!rstn) begin
            m_busy = 0; m_rdy = 0; m_cs = 0; m_rv = 0;
            m_txn = 0; m_errs = 0; m_tmos = 0;
            for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        end else if (m_rv) begin
            if (rsp_ready) begin
                m_rv = 0; m_busy = 0; m_rdy = 1;
                m_txn++;
                if (m_to) m_tmos++;
                else if (m_err) m_errs++;
            end
        end else if (!m_busy) begin
            if (m_rdy && cmd_valid) begin
                m_busy = 1; m_rdy = 0; m_cs = 1; m_age = 0;
                m_rnw = cmd_rnw; m_addr = cmd_addr; m_wdat = cmd_data; m_be = cmd_be;
                if (m_rnw ? rd_map(m_addr) : wr_map(m_addr)) begin
                    m_lat = 2; m_to = 0; m_err = slv_err;
                    if (!m_rnw) begin
                        m_rdat = 32'h0;
                        m_shadow[m_addr[3:2]] = be_merge(m_shadow[m_addr[3:2]], m_wdat, m_be);
                    end else if (m_addr[4:2] >= 3'd4) begin
                        m_rdat = (m_addr[4:2] == 3'd4) ? RO0_VAL : RO1_VAL;
                    end else begin
                        m_rdat = m_shadow[m_addr[3:2]];
                    end
                end else begin
                    m_lat = TMO; m_to = 1; m_err = 1; m_rdat = 32'hFFFF_FFFF;
                end
            end else begin
                m_rdy = 1;
            end
        end else begin
            m_age++;
            if (m_age == m_lat) begin
                m_cs = 0; m_rv = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("cs", Bus2IP_CS, m_cs);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("cmd_ready", cmd_ready, m_rdy);
            if (m_rv) begin
                chk("rsp_data", rsp_data, m_rdat);
                chk("rsp_error", rsp_error, m_err);
            end
            if (m_cs) begin
                chk("bus addr", Bus2IP_Addr, m_addr);
                chk("bus rnw", Bus2IP_RNW, m_rnw);
                chk("bus data", Bus2IP_Data, m_wdat);
                chk("bus be", Bus2IP_BE, m_be);
            end
`ifdef IPIF_REG_MASTER_STATS_EN
            chk("stat_txn", stat_txn_count, m_txn);
            chk("stat_err", stat_err_count, m_errs);
            chk("stat_tmo", stat_timeout_count, m_tmos);
`endif
        end
    end

    // ---------------- directed stimulus (called and returning at a negedge)
    task automatic do_cmd(input logic rnw, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic re, output int lat, output int csn);
        int n;
        rd = '0; re = 1'b0; lat = 0; csn = 0;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_data = wdat; cmd_be = be;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept wait", cmd_ready, 1'b1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 100) begin
            if (Bus2IP_CS) csn++;
            @(negedge clk);
            lat++;
        end
        chk("response wait", rsp_valid, 1'b1);
        if (!rsp_valid) return;
        rd = rsp_data;
        re = rsp_error;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post-hs cmd_ready", cmd_ready, 1'b1);
        chk("post-hs rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat, csn, n;
        int          acc_cyc[$];

        repeat (3) @(negedge clk);
        chk("reset cs", Bus2IP_CS, 1'b0);
        chk("reset rnw", Bus2IP_RNW, 1'b1);
        chk("reset addr", Bus2IP_Addr, 32'h0);
        chk("reset data", Bus2IP_Data, 32'h0);
        chk("reset be", Bus2IP_BE, 4'h0);
        chk("reset cmd_ready", cmd_ready, 1'b0);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_data", rsp_data, 32'h0);
        chk("reset rsp_error", rsp_error, 1'b0);
        rstn = 1'b1;

        // 1: write WO0
        do_cmd(1'b0, 32'h0, 32'h12345678, 4'hF, 0, rd, re, lat, csn);
        chk("t1 cs cycles", csn, 2);
        chk("t1 rsp_data", rd, 32'h0);
        chk("t1 rsp_error", re, 1'b0);
        chk("t1 slave reg", slv_regs[0], 32'h12345678);

        // 2: read RO0, slave re-acks after CS drop
        do_cmd(1'b1, 32'h10, 32'h0, 4'hF, 0, rd, re, lat, csn);
        chk("t2 latency", lat, 2);
        chk("t2 rsp_data", rd, 32'hCAFEF00D);
        chk("t2 rsp_error", re, 1'b0);

        // 3: read write-only register -> no ack -> timeout
        do_cmd(1'b1, 32'h0, 32'h0, 4'hF, 0, rd, re, lat, csn);
        chk("t3 cs cycles", csn, 16);
        chk("t3 latency", lat, 16);
        chk("t3 rsp_data", rd, 32'hFFFFFFFF);
        chk("t3 rsp_error", re, 1'b1);

        // 3b: wrong-type ack (WrAck during a read) must not complete the read
        junk_wrack = 1;
        do_cmd(1'b1, 32'h4, 32'h0, 4'hF, 0, rd, re, lat, csn);
        junk_wrack = 0;
        chk("t3b latency", lat, 16);
        chk("t3b rsp_error", re, 1'b1);

        // 4: response held for 10 cycles
        do_cmd(1'b1, 32'h10, 32'h0, 4'hF, 10, rd, re, lat, csn);
        chk("t4 rsp_data", rd, 32'hCAFEF00D);

        // byte enables on a read/write register
        do_cmd(1'b0, 32'h8, 32'h11223344, 4'hF, 0, rd, re, lat, csn);
        do_cmd(1'b0, 32'h8, 32'hAABBCCDD, 4'h3, 0, rd, re, lat, csn);
        do_cmd(1'b1, 32'h8, 32'h0, 4'hF, 0, rd, re, lat, csn);
        chk("be merge readback", rd, 32'h1122CCDD);

        // back-to-back throughput with rsp_ready held high
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h14; cmd_data = 32'h0; cmd_be = 4'hF;
        repeat (14) begin
            if (cmd_ready) acc_cyc.push_back(cyc);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b accepts", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("b2b spacing", acc_cyc[i] - acc_cyc[i-1], 4);

        // 5: reset during ACCESS
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0; cmd_be = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 cs before reset", Bus2IP_CS, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t5 cs after reset", Bus2IP_CS, 1'b0);
        chk("t5 rsp_valid after reset", rsp_valid, 1'b0);
        rstn = 1'b1;

        // 6: slave error with WrAck
        slv_err = 1;
        do_cmd(1'b0, 32'h8, 32'h0BADF00D, 4'hF, 0, rd, re, lat, csn);
        slv_err = 0;
        chk("t6 rsp_error", re, 1'b1);
        chk("t6 rsp_data", rd, 32'h0);
`ifdef IPIF_REG_MASTER_STATS_EN
        chk("t6 stat_err", stat_err_count, 16'd1);
        chk("t6 stat_txn", stat_txn_count, 32'd1);
`endif

        // normal traffic after reset
        do_cmd(1'b0, 32'hC, 32'hDEADBEEF, 4'hF, 0, rd, re, lat, csn);
        chk("t5 write err", re, 1'b0);
        do_cmd(1'b1, 32'hC, 32'h0, 4'hF, 0, rd, re, lat, csn);
        chk("t5 readback", rd, 32'hDEADBEEF);
        chk("t5 read latency", lat, 2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
